branch_rs: RTL and testbench
============================

# branch_rs

In-order reservation station feeding the branch execution unit. Accepts decoded branch/jump micro-ops from dispatch and holds them until their source operands arrive on the common data bus (CDB). Issues the oldest entry, once it is operand-complete, as the 106-bit packed operand bundle plus PC consumed by the branch executor. Branches never issue out of program order.

## Interface
- DEPTH, 4: number of entries, power of two, at least 2.
- TAG_W, 6: width of a physical-register/ROB tag.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  misprediction/exception flush; discards all entries.
- dispatch_valid  in  1  dispatch offers a micro-op.
- dispatch_ready  out  1  station can accept this cycle.
- dispatch_op  in  5  bits [4:3] select the class: 10 JAL, 11 JALR, 00 conditional; bits [2:0] carry funct3.
- dispatch_rd  in  5  destination register; 0 for conditional branches.
- dispatch_pc  in  32  PC of the micro-op.
- dispatch_imm  in  32  sign-extended immediate.
- dispatch_src1_ready, dispatch_src2_ready  in  1 each  operand value is already valid.
- dispatch_src1_tag, dispatch_src2_tag  in  TAG_W each  producer tag when the operand is not ready.
- dispatch_src1_val, dispatch_src2_val  in  32 each  operand value when ready.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- issue_valid  out  1  drives the executor enable.
- issue_rs  out  106  packed bundle {op[4:0], rd[4:0], src1[31:0], src2[31:0], imm[31:0]}, most significant field first.
- issue_pc  out  32  PC of the issued op.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Entries form a circular FIFO with head and tail pointers of width $clog2(DEPTH), plus the count.
- Dispatch:
  - The transfer occurs when dispatch_valid && dispatch_ready.
  - dispatch_ready = (count != DEPTH) && !flush. It does not account for a same-cycle issue, so a full station never accepts.
  - Operands not needed by the op are forced ready at write: JAL needs neither source; JALR needs src1 only.
- Wakeup:
  - Each valid, not-ready operand compares its tag against cdb_tag while cdb_valid is high.
  - On a match, the operand captures cdb_data and becomes ready.
  - A dispatch operand whose tag matches the CDB broadcast in the same cycle is written as ready with cdb_data. This same-cycle capture is mandatory for correctness and is unaffected by the configuration macro.
- Select: only the head entry is a candidate. It issues when it is valid and both operands are ready.
- Issue:
  - On issue, the bundle and PC are registered into issue_rs/issue_pc and issue_valid is set for exactly one cycle.
  - The head pointer advances and count decrements.
  - The executor has no backpressure, so issue is fire-and-forget.
- Flush:
  - All entries are invalidated, count and pointers return to 0, and issue_valid is 0 in the next cycle.
  - A dispatch presented in the flush cycle is dropped.
  - A head that would have issued in the flush cycle does not issue.
- Simultaneous dispatch and issue: both take effect and count is unchanged.
- Pointer wrap: pointers wrap modulo DEPTH. Full and empty are determined from count, not from pointer equality.

## Timing
- Reset values: issue_valid=0, issue_rs=0, issue_pc=0, count=0, all entry valid bits 0, pointers 0. dispatch_ready is 1 after reset.
- Dispatch of a fully ready op at cycle t: head selectable at t+1, issue_valid high at t+2. With an empty station, back-to-back ready ops issue every cycle.
- Operand arriving on the CDB at cycle t with the head otherwise ready:
  - Without bypass: issue_valid at t+2.
  - With bypass: issue_valid at t+1.
- issue_rs/issue_pc are held stable while issue_valid=0. Their contents are don't-care and must not be relied on.
- Reset asserted mid-operation clears state asynchronously. Any in-flight issue is lost.

## Configuration
- BRANCH_RS_BYPASS_EN defined:
  - The head becomes selectable in the same cycle its last missing operand matches the CDB.
  - cdb_data is muxed into the issued bundle for that operand.
- Undefined:
  - The head is selectable only from the entry's stored ready bits, one cycle later.
  - Functional results are identical; only latency differs.

## Structure
- Shared package branch_pkg holds:
  - Op-class constants OP_JAL=2'b10, OP_JALR=2'b11, OP_BCOND=2'b00.
  - Localparam BRANCH_RS_W=106.
  - Packed struct branch_rs_bundle_t with fields in the order given for issue_rs.
  - Entry struct branch_rs_entry_t: valid, op, rd, pc, imm, and per operand ready/tag/val.
- One sub-module, branch_rs_wakeup: per-operand tag compare and capture, instantiated twice per entry and once per dispatch operand.

## Test plan
- Reset, then dispatch JAL pc=0x100 imm=0x20 rd=1 -> two cycles later issue_valid=1, issue_rs op=5'b10000, rd=1, imm=0x20, issue_pc=0x100.
- Dispatch BEQ with src1 tag 5 not ready and src2=7 ready; three idle cycles; cdb_tag=5, cdb_data=7 at cycle t -> issue at t+2 (t+1 with BRANCH_RS_BYPASS_EN), src1=7 in the bundle.
- Dispatch BNE with src1 tag 9 while cdb_valid, cdb_tag=9, cdb_data=0xABCD in the same cycle -> entry written as ready, issues with src1=0xABCD.
- Fill 4 entries with the head waiting on tag 3 -> dispatch_ready=0, count=4; broadcast tag 3 -> head issues, count=3, dispatch_ready=1; further entries issue in order after wrap.
- Older entry waiting, younger entry ready -> no issue until the older one wakes; issue order matches dispatch order.
- 3 entries held, flush asserted together with dispatch_valid -> count=0 next cycle, dispatched op dropped, no issue_valid.

Source files
------------

// File: rtl/branch_rs_pkg.sv
// Shared types and constants for the branch reservation station.
// Op classes, the issued bundle layout and the entry record live here.
package branch_pkg;

  localparam int BRANCH_RS_W  = 106;
  localparam int BRANCH_TAG_W = 6;

  localparam logic [1:0] OP_JAL   = 2'b10;
  localparam logic [1:0] OP_JALR  = 2'b11;
  localparam logic [1:0] OP_BCOND = 2'b00;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
  } branch_rs_bundle_t;

  typedef struct packed {
    logic                    valid;
    logic [4:0]              op;
    logic [4:0]              rd;
    logic [31:0]             pc;
    logic [31:0]             imm;
    logic                    src1_ready;
    logic [BRANCH_TAG_W-1:0] src1_tag;
    logic [31:0]             src1_val;
    logic                    src2_ready;
    logic [BRANCH_TAG_W-1:0] src2_tag;
    logic [31:0]             src2_val;
  } branch_rs_entry_t;

  function automatic logic needs_src1(input logic [4:0] op);
    return op[4:3] != OP_JAL;
  endfunction

  // Class 2'b01 is unassigned; it is treated like a conditional branch.
  function automatic logic needs_src2(input logic [4:0] op);
    return (op[4:3] == OP_BCOND) || (op[4:3] == 2'b01);
  endfunction

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch, CDB, flush and issue signals of the branch reservation station.
// master = dispatch/CDB/executor side, slave = the station.
interface branch_rs_if
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = BRANCH_TAG_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   flush;
  logic                   dispatch_valid;
  logic                   dispatch_ready;
  logic [4:0]             dispatch_op;
  logic [4:0]             dispatch_rd;
  logic [31:0]            dispatch_pc;
  logic [31:0]            dispatch_imm;
  logic                   dispatch_src1_ready;
  logic                   dispatch_src2_ready;
  logic [TAG_W-1:0]       dispatch_src1_tag;
  logic [TAG_W-1:0]       dispatch_src2_tag;
  logic [31:0]            dispatch_src1_val;
  logic [31:0]            dispatch_src2_val;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [31:0]            cdb_data;
  logic                   issue_valid;
  logic [BRANCH_RS_W-1:0] issue_rs;
  logic [31:0]            issue_pc;
  logic [CNT_W-1:0]       count;

  modport master (
    output flush, dispatch_valid, dispatch_op, dispatch_rd, dispatch_pc, dispatch_imm,
           dispatch_src1_ready, dispatch_src2_ready, dispatch_src1_tag, dispatch_src2_tag,
           dispatch_src1_val, dispatch_src2_val, cdb_valid, cdb_tag, cdb_data,
    input  dispatch_ready, issue_valid, issue_rs, issue_pc, count
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_op, dispatch_rd, dispatch_pc, dispatch_imm,
           dispatch_src1_ready, dispatch_src2_ready, dispatch_src1_tag, dispatch_src2_tag,
           dispatch_src1_val, dispatch_src2_val, cdb_valid, cdb_tag, cdb_data,
    output dispatch_ready, issue_valid, issue_rs, issue_pc, count
  );

endinterface

// File: rtl/branch_rs_wakeup.sv
// Single-operand CDB wakeup: tag compare and capture of the broadcast value.
// Purely combinational; the caller registers out_ready/out_val.
module branch_rs_wakeup
  import branch_pkg::*;
#(
  parameter int TAG_W = BRANCH_TAG_W
) (
  input  logic             en,
  input  logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             out_ready,
  output logic [31:0]      out_val
);

  logic hit;

  assign hit       = en && !in_ready && cdb_valid && (in_tag == cdb_tag);
  assign out_ready = in_ready || hit;
  assign out_val   = hit ? cdb_data : in_val;

endmodule

// File: rtl/branch_rs.sv
// In-order branch reservation station: circular FIFO, CDB wakeup, head-only issue.
// Define BRANCH_RS_BYPASS_EN to let the head issue in the cycle its last operand arrives.
module branch_rs
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = BRANCH_TAG_W
) (
  input  logic       clk,
  input  logic       reset,
  branch_rs_if.slave rs
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  branch_rs_entry_t       entries_q [DEPTH];
  branch_rs_entry_t       entries_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [BRANCH_RS_W-1:0] issue_rs_q, issue_rs_d;
  logic [31:0]            issue_pc_q, issue_pc_d;

  logic [DEPTH-1:0] e1_rdy, e2_rdy;
  logic [31:0]      e1_val [DEPTH];
  logic [31:0]      e2_val [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    branch_rs_wakeup #(.TAG_W(TAG_W)) u_src1 (
      .en        (entries_q[i].valid),
      .in_ready  (entries_q[i].src1_ready),
      .in_tag    (entries_q[i].src1_tag),
      .in_val    (entries_q[i].src1_val),
      .cdb_valid (rs.cdb_valid),
      .cdb_tag   (rs.cdb_tag),
      .cdb_data  (rs.cdb_data),
      .out_ready (e1_rdy[i]),
      .out_val   (e1_val[i])
    );
    branch_rs_wakeup #(.TAG_W(TAG_W)) u_src2 (
      .en        (entries_q[i].valid),
      .in_ready  (entries_q[i].src2_ready),
      .in_tag    (entries_q[i].src2_tag),
      .in_val    (entries_q[i].src2_val),
      .cdb_valid (rs.cdb_valid),
      .cdb_tag   (rs.cdb_tag),
      .cdb_data  (rs.cdb_data),
      .out_ready (e2_rdy[i]),
      .out_val   (e2_val[i])
    );
  end

  // Unneeded operands are forced ready before the compare so they never capture.
  logic        d1_in_rdy, d2_in_rdy;
  logic        d1_rdy, d2_rdy;
  logic [31:0] d1_val, d2_val;

  assign d1_in_rdy = rs.dispatch_src1_ready || !needs_src1(rs.dispatch_op);
  assign d2_in_rdy = rs.dispatch_src2_ready || !needs_src2(rs.dispatch_op);

  branch_rs_wakeup #(.TAG_W(TAG_W)) u_dsrc1 (
    .en        (1'b1),
    .in_ready  (d1_in_rdy),
    .in_tag    (rs.dispatch_src1_tag),
    .in_val    (rs.dispatch_src1_val),
    .cdb_valid (rs.cdb_valid),
    .cdb_tag   (rs.cdb_tag),
    .cdb_data  (rs.cdb_data),
    .out_ready (d1_rdy),
    .out_val   (d1_val)
  );

  branch_rs_wakeup #(.TAG_W(TAG_W)) u_dsrc2 (
    .en        (1'b1),
    .in_ready  (d2_in_rdy),
    .in_tag    (rs.dispatch_src2_tag),
    .in_val    (rs.dispatch_src2_val),
    .cdb_valid (rs.cdb_valid),
    .cdb_tag   (rs.cdb_tag),
    .cdb_data  (rs.cdb_data),
    .out_ready (d2_rdy),
    .out_val   (d2_val)
  );

  branch_rs_entry_t  head_e;
  branch_rs_entry_t  new_e;
  branch_rs_bundle_t bundle;
  logic              head_fire;
  logic [31:0]       head_src1, head_src2;
  logic              disp_ready, do_dispatch, do_issue;

  assign head_e = entries_q[head_q];

`ifdef BRANCH_RS_BYPASS_EN
  assign head_fire = head_e.valid && e1_rdy[head_q] && e2_rdy[head_q];
  assign head_src1 = e1_val[head_q];
  assign head_src2 = e2_val[head_q];
`else
  assign head_fire = head_e.valid && head_e.src1_ready && head_e.src2_ready;
  assign head_src1 = head_e.src1_val;
  assign head_src2 = head_e.src2_val;
`endif

  assign bundle      = {head_e.op, head_e.rd, head_src1, head_src2, head_e.imm};
  assign disp_ready  = (count_q != CNT_W'(DEPTH)) && !rs.flush;
  assign do_dispatch = rs.dispatch_valid && disp_ready;
  assign do_issue    = head_fire && !rs.flush;

  always_comb begin
    new_e            = '0;
    new_e.valid      = 1'b1;
    new_e.op         = rs.dispatch_op;
    new_e.rd         = rs.dispatch_rd;
    new_e.pc         = rs.dispatch_pc;
    new_e.imm        = rs.dispatch_imm;
    new_e.src1_ready = d1_rdy;
    new_e.src1_tag   = rs.dispatch_src1_tag;
    new_e.src1_val   = d1_val;
    new_e.src2_ready = d2_rdy;
    new_e.src2_tag   = rs.dispatch_src2_tag;
    new_e.src2_val   = d2_val;
  end

  always_comb begin
    entries_d     = entries_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    issue_valid_d = do_issue;
    issue_rs_d    = issue_rs_q;
    issue_pc_d    = issue_pc_q;

    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i].src1_ready = e1_rdy[i];
      entries_d[i].src1_val   = e1_val[i];
      entries_d[i].src2_ready = e2_rdy[i];
      entries_d[i].src2_val   = e2_val[i];
    end

    if (do_issue) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PTR_W'(1);
      issue_rs_d              = bundle;
      issue_pc_d              = head_e.pc;
    end

    // Full and empty never coincide with a same-cycle issue/dispatch on one slot.
    if (do_dispatch) begin
      entries_d[tail_q] = new_e;
      tail_d            = tail_q + PTR_W'(1);
    end

    case ({do_dispatch, do_issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (rs.flush) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_rs_q    <= '0;
      issue_pc_q    <= '0;
    end else begin
      entries_q     <= entries_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_rs_q    <= issue_rs_d;
      issue_pc_q    <= issue_pc_d;
    end
  end

  assign rs.dispatch_ready = disp_ready;
  assign rs.issue_valid    = issue_valid_q;
  assign rs.issue_rs       = issue_rs_q;
  assign rs.issue_pc       = issue_pc_q;
  assign rs.count          = count_q;

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: an in-order queue model predicts every issue,
// its cycle and contents; a negedge monitor compares them as the DUT issues.
module tb_branch_rs;
  import branch_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
`ifdef BRANCH_RS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_rs_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  branch_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (bus)
  );

  typedef struct {
    logic [4:0]       op;
    logic [4:0]       rd;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v1;
    logic             r2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      v2;
  } m_ent_t;

  typedef struct {
    logic [105:0] rs;
    logic [31:0]  pc;
    int           edge_n;
  } exp_t;

  m_ent_t mq[$];
  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_vec = 0;
  int     n_mis = 0;
  int     edge_cnt = 0;
  bit     started = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    bus.dispatch_valid = 1'b0;
    bus.cdb_valid      = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] pc,
                      input logic [31:0] imm, input logic r1, input logic [TAG_W-1:0] t1,
                      input logic [31:0] v1, input logic r2, input logic [TAG_W-1:0] t2,
                      input logic [31:0] v2);
    bus.dispatch_valid      = 1'b1;
    bus.dispatch_op         = op;
    bus.dispatch_rd         = rd;
    bus.dispatch_pc         = pc;
    bus.dispatch_imm        = imm;
    bus.dispatch_src1_ready = r1;
    bus.dispatch_src1_tag   = t1;
    bus.dispatch_src1_val   = v1;
    bus.dispatch_src2_ready = r2;
    bus.dispatch_src2_tag   = t2;
    bus.dispatch_src2_val   = v2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  // Program-order queue; the oldest op leaves once both of its operands are known.
  function automatic void model_edge();
    int          sz;
    bit          can_take;
    bit          r1, r2;
    logic [31:0] v1, v2;
    m_ent_t      h, n;
    sz       = mq.size();
    can_take = (sz != DEPTH);
    if (bus.flush) begin
      mq.delete();
      return;
    end
    if (sz > 0) begin
      h  = mq[0];
      r1 = h.r1; v1 = h.v1;
      r2 = h.r2; v2 = h.v2;
      if (BYP && bus.cdb_valid) begin
        if (!r1 && h.t1 == bus.cdb_tag) begin r1 = 1'b1; v1 = bus.cdb_data; end
        if (!r2 && h.t2 == bus.cdb_tag) begin r2 = 1'b1; v2 = bus.cdb_data; end
      end
      if (r1 && r2) begin
        exp_q.push_back('{rs: {h.op, h.rd, v1, v2, h.imm}, pc: h.pc, edge_n: edge_cnt});
        mq.delete(0);
      end
    end
    if (bus.cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].r1 && mq[i].t1 == bus.cdb_tag) begin mq[i].r1 = 1'b1; mq[i].v1 = bus.cdb_data; end
        if (!mq[i].r2 && mq[i].t2 == bus.cdb_tag) begin mq[i].r2 = 1'b1; mq[i].v2 = bus.cdb_data; end
      end
    end
    if (bus.dispatch_valid && can_take) begin
      n.op  = bus.dispatch_op;
      n.rd  = bus.dispatch_rd;
      n.pc  = bus.dispatch_pc;
      n.imm = bus.dispatch_imm;
      n.t1  = bus.dispatch_src1_tag;
      n.t2  = bus.dispatch_src2_tag;
      n.v1  = bus.dispatch_src1_val;
      n.v2  = bus.dispatch_src2_val;
      // JAL uses no register source; JALR uses only src1.
      n.r1  = bus.dispatch_src1_ready || (bus.dispatch_op[4:3] == 2'b10);
      n.r2  = bus.dispatch_src2_ready || bus.dispatch_op[4];
      if (bus.cdb_valid && !n.r1 && n.t1 == bus.cdb_tag) begin n.r1 = 1'b1; n.v1 = bus.cdb_data; end
      if (bus.cdb_valid && !n.r2 && n.t2 == bus.cdb_tag) begin n.r2 = 1'b1; n.v2 = bus.cdb_data; end
      mq.push_back(n);
    end
  endfunction

  task automatic tick();
    #1;
    check("count", 128'(bus.count), 128'(mq.size()));
    check("dispatch_ready", 128'(bus.dispatch_ready), 128'((mq.size() != DEPTH) && !bus.flush));
    @(posedge clk);
    edge_cnt++;
    model_edge();
    @(negedge clk);
    idle_inputs();
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      if (bus.issue_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_issue: actual issue_valid=1 pc=%0h, required no issue", bus.issue_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_cycle", 128'(edge_cnt), 128'(mon_e.edge_n));
          check("issue_rs", 128'(bus.issue_rs), 128'(mon_e.rs));
          check("issue_pc", 128'(bus.issue_pc), 128'(mon_e.pc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt) begin
        n_vec++;
        n_mis++;
        $display("FAIL missed_issue: actual issue_valid=0, required issue pc=%0h", exp_q[0].pc);
        exp_q.delete(0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    disp(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, '0, 32'd0, 1'b0, '0, 32'd0);
    bus.dispatch_valid = 1'b0;
    bus.cdb_tag  = '0;
    bus.cdb_data = '0;
    repeat (2) @(negedge clk);
    check("reset_count", 128'(bus.count), 128'(0));
    check("reset_issue_valid", 128'(bus.issue_valid), 128'(0));
    check("reset_issue_rs", 128'(bus.issue_rs), 128'(0));
    check("reset_issue_pc", 128'(bus.issue_pc), 128'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    started = 1'b1;

    // JAL, fully ready
    disp(5'b10000, 5'd1, 32'h100, 32'h20, 1'b0, 6'd0, $urandom, 1'b0, 6'd0, $urandom);
    tick();
    repeat (3) tick();

    // BEQ waiting on tag 5
    disp(5'b00000, 5'd0, 32'h200, 32'h40, 1'b0, 6'd5, 32'd0, 1'b1, 6'd0, 32'd7);
    tick();
    repeat (3) tick();
    cdb(6'd5, 32'd7);
    tick();
    repeat (3) tick();

    // BNE captured from the CDB in its dispatch cycle
    cdb(6'd9, 32'hABCD);
    disp(5'b00001, 5'd0, 32'h300, 32'h8, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'h55);
    tick();
    repeat (3) tick();

    // fill to full behind a head waiting on tag 3, then wrap
    disp(5'b00100, 5'd0, 32'h400, 32'h10, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      disp(5'b11000, 5'd2, 32'h400 + 32'(4 * k), 32'(k), 1'b1, 6'd0, 32'(k * 11), 1'b0, 6'd1, 32'd0);
      tick();
    end
    disp(5'b10000, 5'd3, 32'h4F0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    tick();
    tick();
    cdb(6'd3, 32'h33);
    tick();
    for (int k = 0; k < 3; k++) begin
      disp(5'b00101, 5'd0, 32'h500 + 32'(4 * k), 32'd2, 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'd9);
      tick();
    end
    repeat (6) tick();

    // older waits, younger ready: order preserved
    disp(5'b00110, 5'd0, 32'h600, 32'd4, 1'b1, 6'd0, 32'd1, 1'b0, 6'd12, 32'd0);
    tick();
    disp(5'b10000, 5'd5, 32'h604, 32'd8, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    tick();
    repeat (3) tick();
    cdb(6'd12, 32'hC0DE);
    tick();
    repeat (4) tick();

    // flush with three held entries and a concurrent dispatch
    for (int k = 0; k < 3; k++) begin
      disp(5'b00000, 5'd0, 32'h700 + 32'(4 * k), 32'd0, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd0);
      tick();
    end
    bus.flush = 1'b1;
    disp(5'b10000, 5'd7, 32'h7F0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    tick();
    cdb(6'd20, 32'h1);
    tick();
    repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0)
        disp({2'($urandom_range(0, 3)), 3'($urandom)}, 5'($urandom), $urandom, $urandom,
             1'($urandom), 6'($urandom_range(0, 7)), $urandom,
             1'($urandom), 6'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) != 0) cdb(6'($urandom_range(0, 7)), $urandom);
      bus.flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    for (int t = 0; t < 8; t++) begin
      cdb(6'(t), $urandom);
      tick();
    end
    repeat (4) tick();

    // asynchronous reset with an issue about to happen
    disp(5'b10000, 5'd9, 32'h900, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    tick();
    disp(5'b10000, 5'd9, 32'h904, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_count", 128'(bus.count), 128'(0));
    check("async_reset_issue_valid", 128'(bus.issue_valid), 128'(0));
    mq.delete();
    exp_q.delete();
    idle_inputs();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    disp(5'b10000, 5'd4, 32'hA00, 32'h4, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    tick();
    repeat (4) tick();

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
